gauss_dispatcher: RTL and testbench
===================================

# gauss_dispatcher

Issue-side initiator for the Gauss functional unit. Accepts tagged operand requests, buffers them in a small FIFO, and launches one operation at a time to the functional unit with a start pulse. It waits for the unit's done strobe and returns the result with its tag over a valid/ready response port. A watchdog turns a hung operation into an error response, so the pipeline never stalls forever.

## Interface
- DATA_W, 16, operand/result width
- TAG_W, 3, request tag width
- DEPTH, 4, request FIFO entries (power of two, ≥2)
- TIMEOUT, 64, max cycles spent in WAIT before an error response (≥2)

- clk  in  1  clock, all state updates on rising edge
- preset  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  1  request offered
- req_ready  out  1  FIFO can accept (count < DEPTH)
- req_data  in  DATA_W  operand n
- req_tag  in  TAG_W  caller tag
- fu_start  out  1  one-cycle launch pulse to functional unit
- fu_data  out  DATA_W  operand; held stable from LAUNCH until leaving WAIT
- fu_done  in  1  functional unit completion strobe
- fu_result  in  DATA_W  result, valid when fu_done=1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DATA_W  result (0 on error)
- rsp_tag  out  TAG_W  tag of completed request
- rsp_err  out  1  1 = watchdog expired
- busy  out  1  FSM not in IDLE or FIFO non-empty
- count  out  clog2(DEPTH)+1  FIFO occupancy

## Operation
- Reset (preset=0, immediate, clock-independent): FSM=IDLE, FIFO empty, count=0, req_ready=1, fu_start=0, fu_data=0, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0, busy=0, timer=0. Any in-flight operation is abandoned. A late fu_done after reset is ignored.
- Push: a request is accepted on an edge where req_valid & req_ready. The FIFO stores {tag,data}.
- Pop: happens on the IDLE→LAUNCH edge. Push and pop on the same edge are both honoured, and count is unchanged. When full, the same-edge pop does not make req_ready high within that cycle; req_ready is a function of registered count only.
- Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the op registers (fu_data, tag) and go to LAUNCH.
  - LAUNCH: fu_start=1 for exactly this cycle. Clear timer. Go to WAIT.
  - WAIT: fu_done is sampled only in this state.
    - fu_done=1: rsp_data←fu_result, rsp_err←0, go to RESP.
    - Otherwise, when timer==TIMEOUT-1: rsp_data←0, rsp_err←1, go to RESP.
    - Otherwise, timer+1.
    - If fu_done and the timeout fall on the same edge, fu_done wins (rsp_err=0).
  - RESP: rsp_valid=1, with rsp_data/tag/err stable. On rsp_ready, go to IDLE. rsp_valid is deasserted the following cycle.
- fu_done in IDLE, LAUNCH or RESP is ignored.
- Strictly one operation in flight. Responses leave in request order.

## Timing
- Request accepted at edge k (FIFO previously empty, FSM IDLE): pop at edge k+1; fu_start high during cycle k+1..k+2; WAIT from edge k+2.
- fu_done first sampled at edge k+3. If it is high there, rsp_valid rises after edge k+3. Minimum request-to-response latency is 3 cycles.
- With rsp_ready held high, RESP lasts 1 cycle. Back-to-back operations cost 4 cycles each plus the FU delay.
- Watchdog: error response is registered TIMEOUT cycles after entering WAIT.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold preset=0 with random inputs. All outputs are at their reset values, req_ready=1, and stay stable across clock edges.
- Single op: push n=4, tag=5. The FU model returns 10 two cycles after fu_start. Check fu_start is high exactly once with fu_data=4, and the response has rsp_data=10, rsp_tag=5, rsp_err=0 with a latency of 4 cycles.
- Fill/backpressure: push 5 requests (n=1..5, tags 0..4) with rsp_ready=0. After 4 pushes plus one pop, count settles with req_ready=0 at count=DEPTH. Then release rsp_ready. Responses arrive in order as 1,3,6,10,15 with matching tags, and there is no loss or duplication across the pointer wrap.
- Simultaneous push/pop: push on the same edge as the IDLE pop, with count=2. Count stays 2.
- Watchdog: the FU never asserts done. After TIMEOUT cycles in WAIT: rsp_err=1, rsp_data=0, correct tag. The next queued request then launches normally. A spurious fu_done asserted in RESP is ignored.
- Reset mid-op: assert preset=0 during WAIT. Outputs reset immediately. fu_done then asserted after release produces no response, and a new request completes normally.

Source files
------------

// File: rtl/gauss_dispatcher.sv
// ---------------------------------------------------------------------------
// gauss_dispatcher
//
// Issue-side initiator for the Gauss functional unit. Tagged operand requests
// are queued in a small FIFO. They are launched one at a time to the unit with
// a single-cycle start pulse. The result comes back with its tag over a
// valid/ready response port. A watchdog converts a hung operation into an
// error response, so a dead unit cannot stall the queue forever.
//
// Ports
//   clk        rising-edge clock
//   preset     asynchronous active-low reset
//   req_*      request port (valid/ready); req_ready depends on count only
//   fu_start   one-cycle launch pulse, fu_data held through the wait
//   fu_done    completion strobe with fu_result, only observed while waiting
//   rsp_*      response port (valid/ready); rsp_err=1 means watchdog expiry
//   busy       an operation is in flight or requests are queued
//   count      FIFO occupancy
// ---------------------------------------------------------------------------
module gauss_dispatcher #(
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 3,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     preset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [DATA_W-1:0]        req_data,
    input  logic [TAG_W-1:0]         req_tag,
    output logic                     fu_start,
    output logic [DATA_W-1:0]        fu_data,
    input  logic                     fu_done,
    input  logic [DATA_W-1:0]        fu_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT);

    // Last timer value before the watchdog fires.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } req_t;

    state_t             state, state_nxt;
    req_t               mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [TAG_W-1:0]   op_tag;
    logic [TMR_W-1:0]   timer;
    logic               push, pop;
    logic               wd_fire;

    // Push is gated by the registered-count ready, so a pop on the same edge
    // never lets a full FIFO accept early.
    assign push    = req_valid && req_ready;
    assign pop     = (state == IDLE) && (count != '0);
    // fu_done takes priority over expiry when both land on the same edge.
    assign wd_fire = (state == WAIT) && !fu_done && (timer == TMR_LAST);

    // ------------------------------------------------------------------
    // Request FIFO. The storage needs no reset: an entry is only read after
    // it has been written, and count gates every read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{tag: req_tag, data: req_data};
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != '0) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (fu_done || wd_fire) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM: outputs. These decode registered state and the
    // registered count only, so no input reaches an output combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        fu_start  = (state == LAUNCH);
        rsp_valid = (state == RESP);
        busy      = (state != IDLE) || (count != '0);
        req_ready = (count < CNT_FULL);
    end

    // ------------------------------------------------------------------
    // Operation registers. fu_data and op_tag load only at the pop. This
    // keeps the operand stable from launch until the response is taken.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            fu_data <= '0;
            op_tag  <= '0;
        end else if (pop) begin
            fu_data <= mem[rd_ptr].data;
            op_tag  <= mem[rd_ptr].tag;
        end
    end

    // Watchdog timer: cleared during launch, then counts wait cycles.
    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            timer <= '0;
        end else if (state == LAUNCH) begin
            timer <= '0;
        end else if (state == WAIT && !fu_done && timer != TMR_LAST) begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Response registers are written only when leaving WAIT. A stray fu_done
    // in any other state cannot disturb a pending response.
    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            rsp_data <= '0;
            rsp_tag  <= '0;
            rsp_err  <= 1'b0;
        end else if (state == WAIT) begin
            if (fu_done) begin
                rsp_data <= fu_result;
                rsp_tag  <= op_tag;
                rsp_err  <= 1'b0;
            end else if (wd_fire) begin
                rsp_data <= '0;
                rsp_tag  <= op_tag;
                rsp_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gauss_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_gauss_dispatcher
//
// Directed bench for gauss_dispatcher. A small behavioural Gauss unit answers
// n*(n+1)/2 two cycles after it sees fu_start. It can be muted to emulate a
// hung unit. A manual fu_done/fu_result override is OR-ed onto the model
// outputs to inject spurious or late strobes.
// ---------------------------------------------------------------------------
module tb_gauss_dispatcher;

    localparam int DATA_W  = 16;
    localparam int TAG_W   = 3;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic                  clk    = 1'b0;
    logic                  preset = 1'b1;
    logic                  req_valid, req_ready;
    logic [DATA_W-1:0]     req_data;
    logic [TAG_W-1:0]      req_tag;
    logic                  fu_start;
    logic [DATA_W-1:0]     fu_data;
    logic                  fu_done;
    logic [DATA_W-1:0]     fu_result;
    logic                  rsp_valid, rsp_ready;
    logic [DATA_W-1:0]     rsp_data;
    logic [TAG_W-1:0]      rsp_tag;
    logic                  rsp_err, busy;
    logic [$clog2(DEPTH):0] count;

    // Functional unit model plus manual override
    logic              fu_en       = 1'b1;
    logic              fu_done_mdl = 1'b0;
    logic              fu_done_man = 1'b0;
    logic [DATA_W-1:0] fu_res_mdl  = '0;
    logic [DATA_W-1:0] fu_res_man  = '0;
    int                fu_cnt      = 0;
    int                fu_op       = 0;

    assign fu_done   = fu_done_mdl | fu_done_man;
    assign fu_result = fu_done_man ? fu_res_man : fu_res_mdl;

    int tests = 0;
    int fails = 0;
    int n, starts, seen;
    logic [DATA_W-1:0] sdata;

    always #5 clk = ~clk;

    gauss_dispatcher #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .preset    (preset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_tag   (req_tag),
        .fu_start  (fu_start),
        .fu_data   (fu_data),
        .fu_done   (fu_done),
        .fu_result (fu_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .count     (count)
    );

    // fu_start is seen at the negedge inside the launch cycle. Done is then
    // raised two negedges later, so it is sampled on the second rising edge
    // after the DUT enters WAIT.
    always @(negedge clk) begin
        fu_done_mdl = 1'b0;
        if (!preset) begin
            fu_cnt = 0;
        end else begin
            if (fu_cnt > 0) begin
                fu_cnt--;
                if (fu_cnt == 0 && fu_en) begin
                    fu_done_mdl = 1'b1;
                    fu_res_mdl  = DATA_W'(fu_op * (fu_op + 1) / 2);
                end
            end
            if (fu_start) begin
                fu_cnt = 2;
                fu_op  = int'(fu_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input int t);
        req_valid = 1'b1;
        req_data  = DATA_W'(d);
        req_tag   = TAG_W'(t);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        req_valid = 1'b0; req_data = '0; req_tag = '0; rsp_ready = 1'b0;
        #2 preset = 1'b0;

        // ---------------- reset with random inputs ----------------
        for (int i = 0; i < 4; i++) begin
            req_valid   = 1'($urandom);
            req_data    = DATA_W'($urandom);
            req_tag     = TAG_W'($urandom);
            rsp_ready   = 1'($urandom);
            fu_done_man = 1'($urandom);
            fu_res_man  = DATA_W'($urandom);
            tick();
            chk("rst_flags", 32'({req_ready, fu_start, rsp_valid, rsp_err, busy}), 32'b10000);
            chk("rst_fu_data", 32'(fu_data), 0);
            chk("rst_rsp_data", 32'(rsp_data), 0);
            chk("rst_rsp_tag", 32'(rsp_tag), 0);
            chk("rst_count", 32'(count), 0);
        end
        req_valid = 1'b0; rsp_ready = 1'b0; fu_done_man = 1'b0;
        preset = 1'b1;
        tick(); tick();

        // ---------------- single op ----------------
        rsp_ready = 1'b1;
        push(4, 5);
        chk("single_count", 32'(count), 1);
        starts = 0; n = 0; sdata = '0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
            if (fu_start) begin
                starts++;
                sdata = fu_data;
            end
        end
        chk("single_latency", 32'(n), 4);
        chk("single_starts", 32'(starts), 1);
        chk("single_fu_data", 32'(sdata), 4);
        chk("single_rsp_data", 32'(rsp_data), 10);
        chk("single_rsp_tag", 32'(rsp_tag), 5);
        chk("single_rsp_err", 32'(rsp_err), 0);
        tick();
        chk("single_rsp_drop", 32'(rsp_valid), 0);
        chk("single_idle", 32'({busy, fu_start}), 0);

        // ---------------- fill / backpressure / wrap ----------------
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(i + 1, i);
        chk("fill_count", 32'(count), DEPTH);
        chk("fill_ready", 32'(req_ready), 0);
        push(99, 7);  // must be refused while full
        chk("fill_no_overflow", 32'(count), DEPTH);
        wait_rsp(20, n);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(40, n);
            chk("fill_valid", 32'(rsp_valid), 1);
            chk("fill_data", 32'(rsp_data), 32'((i + 1) * (i + 2) / 2));
            chk("fill_tag", 32'(rsp_tag), 32'(i));
            chk("fill_err", 32'(rsp_err), 0);
            tick();
        end
        tick();
        chk("fill_drained", 32'({busy, rsp_valid}), 0);
        chk("fill_count_end", 32'(count), 0);

        // ---------------- simultaneous push/pop ----------------
        rsp_ready = 1'b0;
        push(6, 6);
        push(7, 7);
        push(2, 1);
        wait_rsp(20, n);
        chk("pp_first_data", 32'(rsp_data), 21);
        chk("pp_first_tag", 32'(rsp_tag), 6);
        chk("pp_count_pre", 32'(count), 2);
        rsp_ready = 1'b1;
        tick();  // RESP -> IDLE
        chk("pp_rsp_drop", 32'(rsp_valid), 0);
        push(3, 2);  // lands on the IDLE pop edge
        chk("pp_count_same", 32'(count), 2);
        chk("pp_launch", 32'(fu_start), 1);
        for (int i = 0; i < 3; i++) begin
            wait_rsp(40, n);
            chk("pp_valid", 32'(rsp_valid), 1);
            chk("pp_data", 32'(rsp_data), (i == 0) ? 28 : (i == 1) ? 3 : 6);
            chk("pp_tag", 32'(rsp_tag), (i == 0) ? 7 : (i == 1) ? 1 : 2);
            tick();
        end
        tick();
        chk("pp_drained", 32'(count), 0);

        // ---------------- watchdog ----------------
        fu_en = 1'b0; rsp_ready = 1'b0;
        push(5, 3);
        push(8, 4);
        n = 0;
        while (!fu_start && n < 10) begin
            tick();
            n++;
        end
        chk("wd_launch", 32'(fu_start), 1);
        wait_rsp(200, n);
        chk("wd_cycles", 32'(n), TIMEOUT + 1);
        chk("wd_err", 32'(rsp_err), 1);
        chk("wd_data", 32'(rsp_data), 0);
        chk("wd_tag", 32'(rsp_tag), 3);
        chk("wd_queued", 32'(count), 1);
        fu_done_man = 1'b1; fu_res_man = 16'h1234;
        tick();
        fu_done_man = 1'b0;
        chk("wd_spur_valid", 32'(rsp_valid), 1);
        chk("wd_spur_data", 32'(rsp_data), 0);
        chk("wd_spur_err", 32'(rsp_err), 1);
        fu_en = 1'b1; rsp_ready = 1'b1;
        tick();
        wait_rsp(20, n);
        chk("wd_next_data", 32'(rsp_data), 36);
        chk("wd_next_tag", 32'(rsp_tag), 4);
        chk("wd_next_err", 32'(rsp_err), 0);
        tick();

        // ---------------- reset mid-op ----------------
        fu_en = 1'b0;
        push(9, 5);
        n = 0;
        while (!fu_start && n < 10) begin
            tick();
            n++;
        end
        tick(); tick(); tick();
        chk("mid_busy", 32'(busy), 1);
        #1 preset = 1'b0;
        #1;
        chk("mid_rst_flags", 32'({req_ready, fu_start, rsp_valid, rsp_err, busy}), 32'b10000);
        chk("mid_rst_fu_data", 32'(fu_data), 0);
        chk("mid_rst_count", 32'(count), 0);
        tick(); tick();
        preset = 1'b1;
        tick();
        fu_en = 1'b1;
        fu_done_man = 1'b1; fu_res_man = 16'h00aa;
        tick();
        fu_done_man = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid || busy) seen++;
            tick();
        end
        chk("mid_late_done_ignored", 32'(seen), 0);
        push(10, 2);
        wait_rsp(20, n);
        chk("mid_new_data", 32'(rsp_data), 55);
        chk("mid_new_tag", 32'(rsp_tag), 2);
        chk("mid_new_err", 32'(rsp_err), 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
